imm_gen_pipe: RTL and testbench

Registered, handshaked immediate generator for the decode/execute boundary of the RV32 core with MAC. It replaces the purely combinational immediate path. It extracts and sign-extends the immediate for every base format plus CSR-zimm and shift-amount. It also precomputes the PC-relative target, `pc + imm`. Results are held in a 2-entry skid buffer so a stalled execute stage never forces a combinational ready path back into decode.

---
 rtl/imm_gen_pipe.sv | 142 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with PC-relative target,
// buffered in a 2-entry skid buffer (head H, skid S) so in_ready is a
// flop output with no combinational path from out_ready.
module imm_gen_pipe #(
  parameter int INST_W = 32,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [2:0]        in_imm_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [PC_W-1:0]   out_target,
  output logic              out_sel_err
);

  // Entry layout: {sel_err, target, imm}
  localparam int ENT_W = DATA_W + PC_W + 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ENT_W-1:0]   h_q, h_d;
  logic [ENT_W-1:0]   s_q, s_d;
  logic [DATA_W-1:0]  new_imm;
  logic               new_err;
  logic [PC_W-1:0]    new_target;
  logic [ENT_W-1:0]   new_ent;
  logic               acc;
  logic               pop;
  logic               unused_opcode;

  // Opcode bits never contribute to any immediate format.
  assign unused_opcode = ^in_inst[6:0];

  // Decode and extend the immediate for the selected format.
  always_comb begin
    new_imm = '0;
    new_err = 1'b0;
    case (in_imm_sel)
      3'b000: new_imm = DATA_W'($signed(in_inst[31:20]));
      3'b001: new_imm = DATA_W'($signed({in_inst[31:25], in_inst[11:7]}));
      3'b010: new_imm = DATA_W'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                         in_inst[11:8], 1'b0}));
      3'b011: new_imm = DATA_W'($signed({in_inst[31:12], 12'b0}));
      3'b100: new_imm = DATA_W'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                         in_inst[30:21], 1'b0}));
      3'b101: new_imm = DATA_W'(in_inst[19:15]);
      3'b110: begin
        if (DATA_W == 64) new_imm = DATA_W'(in_inst[25:20]);
        else              new_imm = DATA_W'(in_inst[24:20]);
      end
      default: begin
        new_imm = '0;
        new_err = 1'b1;
      end
    endcase
  end

  // PC-relative target, wrapping silently modulo 2^PC_W.
  always_comb begin
    new_target = in_pc + PC_W'(new_imm);
    new_ent    = {new_err, new_target, new_imm};
  end

  // Skid-buffer next state and data moves; flush only clears validity.
  always_comb begin
    acc     = in_valid & in_ready_q;
    pop     = out_valid_q & out_ready;
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            h_d     = new_ent;
          end
        end
        ST_ONE: begin
          if (acc && !pop) begin
            state_d = ST_FULL;
            s_d     = new_ent;
          end else if (acc && pop) begin
            h_d     = new_ent;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d = ST_ONE;
            h_d     = s_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State, handshake flags and entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      h_q         <= '0;
      s_q         <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      h_q         <= h_d;
      s_q         <= s_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = h_q[DATA_W-1:0];
  assign out_target  = h_q[DATA_W +: PC_W];
  assign out_sel_err = h_q[ENT_W-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed scenarios plus a randomized
// run against a queue-based reference model; 32- and 64-bit builds side by side.
module tb_imm_gen_pipe;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic [2:0]  in_imm_sel;

  logic        rdy32, vld32, err32;
  logic [31:0] imm32, tgt32;
  logic        rdy64, vld64, err64;
  logic [63:0] imm64;
  logic [31:0] tgt64;

  int passed = 0;
  int total  = 0;

  imm_gen_pipe #(.INST_W(32), .DATA_W(32), .PC_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_pc(in_pc), .in_imm_sel(in_imm_sel),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
    .out_target(tgt32), .out_sel_err(err32)
  );

  imm_gen_pipe #(.INST_W(32), .DATA_W(64), .PC_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_pc(in_pc), .in_imm_sel(in_imm_sel),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
    .out_target(tgt64), .out_sel_err(err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic [63:0] imm64;
    logic [31:0] tgt64;
    logic        err;
  } ent_t;

  // Reference immediate built from field values with plain arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] sel,
                                          input bit w64);
    longint v;
    case (sel)
      3'd0: v = longint'(i[31:20]) - (i[31] ? 64'sd4096 : 64'sd0);
      3'd1: v = longint'({i[31:25], i[11:7]}) - (i[31] ? 64'sd4096 : 64'sd0);
      3'd2: v = 2 * longint'(i[11:8]) + 32 * longint'(i[30:25]) + 2048 * longint'(i[7])
                - (i[31] ? 64'sd4096 : 64'sd0);
      3'd3: v = 4096 * longint'(i[31:12]) - (i[31] ? 64'sh1_0000_0000 : 64'sd0);
      3'd4: v = 2 * longint'(i[30:21]) + 2048 * longint'(i[20]) + 4096 * longint'(i[19:12])
                - (i[31] ? 64'sd1048576 : 64'sd0);
      3'd5: v = longint'(i[19:15]);
      3'd6: v = w64 ? longint'(i[25:20]) : longint'(i[24:20]);
      default: v = 0;
    endcase
    return w64 ? 64'(v) : {32'd0, v[31:0]};
  endfunction

  task automatic test_reset_init();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; in_imm_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (vld32 !== 1'b0 || vld64 !== 1'b0) $display("FAIL rst_valid got %b/%b want 0", vld32, vld64); else passed++;
    total++; if (rdy32 !== 1'b1 || rdy64 !== 1'b1) $display("FAIL rst_ready got %b/%b want 1", rdy32, rdy64); else passed++;
    total++; if (imm32 !== 32'd0 || imm64 !== 64'd0 || tgt32 !== 32'd0 || err32 !== 1'b0)
      $display("FAIL rst_data got imm %h/%h tgt %h err %b want 0", imm32, imm64, tgt32, err32); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_formats();
    logic [31:0] ti  [8] = '{32'hFFF00093, 32'h12345037, 32'h0080006F, 32'h000FD073,
                             32'hFFFFFFFF, 32'h800002B7, 32'h03F00013, 32'hFE000FA3};
    logic [2:0]  ts  [8] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd7, 3'd3, 3'd6, 3'd1};
    logic [31:0] e32 [8] = '{32'hFFFFFFFF, 32'h12345000, 32'h8, 32'h1F, 32'h0,
                             32'h80000000, 32'h1F, 32'hFFFFFFFF};
    logic [63:0] e64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'h12345000, 64'h8, 64'h1F, 64'h0,
                             64'hFFFFFFFF80000000, 64'h3F, 64'hFFFFFFFFFFFFFFFF};
    out_ready = 1'b1; in_pc = 32'h0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_inst = ti[k]; in_imm_sel = ts[k];
      @(posedge clk); #1;
      total++; if (vld32 !== 1'b1 || vld64 !== 1'b1) $display("FAIL fmt%0d_valid got %b/%b want 1", k, vld32, vld64); else passed++;
      total++; if (imm32 !== e32[k]) $display("FAIL fmt%0d_imm32 got %h want %h", k, imm32, e32[k]); else passed++;
      total++; if (imm64 !== e64[k]) $display("FAIL fmt%0d_imm64 got %h want %h", k, imm64, e64[k]); else passed++;
      total++; if (err32 !== (ts[k] == 3'd7) || err64 !== (ts[k] == 3'd7))
        $display("FAIL fmt%0d_err got %b/%b want %b", k, err32, err64, ts[k] == 3'd7); else passed++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (vld32 !== 1'b0) $display("FAIL fmt_drain got %b want 0", vld32); else passed++;
  endtask

  task automatic test_branch_target();
    logic [31:0] pcs  [2] = '{32'h00000100, 32'h00000000};
    logic [31:0] etgt [2] = '{32'h000000FC, 32'hFFFFFFFC};
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_inst = 32'hFE000EE3; in_imm_sel = 3'd2; in_pc = pcs[k];
      @(posedge clk); #1;
      total++; if (imm32 !== 32'hFFFFFFFC || imm64 !== 64'hFFFFFFFFFFFFFFFC)
        $display("FAIL br%0d_imm got %h/%h want FFFFFFFC", k, imm32, imm64); else passed++;
      total++; if (tgt32 !== etgt[k] || tgt64 !== etgt[k])
        $display("FAIL br%0d_target got %h/%h want %h", k, tgt32, tgt64, etgt[k]); else passed++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_imm_sel = 3'd0; in_pc = 32'h0;
    in_valid = 1'b1; in_inst = 32'h00100013;  // A: imm 1
    @(posedge clk); #1;
    total++; if (rdy32 !== 1'b1 || vld32 !== 1'b1 || imm32 !== 32'd1)
      $display("FAIL bp_a got rdy %b vld %b imm %h want 1 1 1", rdy32, vld32, imm32); else passed++;
    in_inst = 32'h00200013;                   // B: imm 2
    @(posedge clk); #1;
    total++; if (rdy32 !== 1'b0 || rdy64 !== 1'b0 || imm32 !== 32'd1)
      $display("FAIL bp_full got rdy %b/%b imm %h want 0 0 1", rdy32, rdy64, imm32); else passed++;
    in_inst = 32'h00300013;                   // C: imm 3, held by source
    @(posedge clk); #1;
    total++; if (rdy32 !== 1'b0 || vld32 !== 1'b1 || imm32 !== 32'd1)
      $display("FAIL bp_stall got rdy %b vld %b imm %h want 0 1 1", rdy32, vld32, imm32); else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (vld32 !== 1'b1 || imm32 !== 32'd2 || imm64 !== 64'd2 || rdy32 !== 1'b1)
      $display("FAIL bp_pop_b got vld %b imm %h rdy %b want 1 2 1", vld32, imm32, rdy32); else passed++;
    @(posedge clk); #1;
    total++; if (vld32 !== 1'b1 || imm32 !== 32'd3 || imm64 !== 64'd3)
      $display("FAIL bp_pop_c got vld %b imm %h want 1 3", vld32, imm32); else passed++;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (vld32 !== 1'b0 || rdy32 !== 1'b1)
      $display("FAIL bp_empty got vld %b rdy %b want 0 1", vld32, rdy32); else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_imm_sel = 3'd0; in_valid = 1'b1;
    in_inst = 32'h00400013;
    @(posedge clk); #1;
    in_inst = 32'h00500013;
    @(posedge clk); #1;
    total++; if (rdy32 !== 1'b0) $display("FAIL fl_fill got rdy %b want 0", rdy32); else passed++;
    flush = 1'b1; out_ready = 1'b1; in_inst = 32'h00600013;
    @(posedge clk); #1;
    total++; if (vld32 !== 1'b0 || vld64 !== 1'b0 || rdy32 !== 1'b1)
      $display("FAIL fl_full got vld %b/%b rdy %b want 0 0 1", vld32, vld64, rdy32); else passed++;
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (vld32 !== 1'b0 || vld64 !== 1'b0)
        $display("FAIL fl_after%0d got vld %b/%b want 0", k, vld32, vld64); else passed++;
    end
    // Flush in ONE with an input offered: both must vanish.
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00700013;
    @(posedge clk); #1;
    flush = 1'b1; in_inst = 32'h00800013;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++; if (vld32 !== 1'b0 || rdy32 !== 1'b1)
      $display("FAIL fl_one got vld %b rdy %b want 0 1", vld32, rdy32); else passed++;
    @(posedge clk); #1;
    total++; if (vld32 !== 1'b0) $display("FAIL fl_one_after got vld %b want 0", vld32); else passed++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_imm_sel = 3'd0; in_pc = 32'h40; in_valid = 1'b1;
    in_inst = 32'h00900013;
    @(posedge clk); #1;
    in_inst = 32'h00A00013;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (rdy32 !== 1'b0 || vld32 !== 1'b1)
      $display("FAIL ar_full got rdy %b vld %b want 0 1", rdy32, vld32); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (vld32 !== 1'b0 || vld64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1)
      $display("FAIL ar_flags got vld %b/%b rdy %b/%b want 0 0 1 1", vld32, vld64, rdy32, rdy64); else passed++;
    total++; if (imm32 !== 32'd0 || imm64 !== 64'd0 || tgt32 !== 32'd0 || err32 !== 1'b0 || err64 !== 1'b0)
      $display("FAIL ar_data got imm %h/%h tgt %h err %b want 0", imm32, imm64, tgt32, err32); else passed++;
    #1 rst = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00B00013;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (vld32 !== 1'b1 || imm32 !== 32'd11 || tgt32 !== 32'h4B)
      $display("FAIL ar_first got vld %b imm %h tgt %h want 1 B 4B", vld32, imm32, tgt32); else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    bit   acc, pop;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      total++; if (vld32 !== (q.size() > 0) || vld64 !== (q.size() > 0))
        $display("FAIL rnd_valid c%0d got %b/%b want %b", cyc, vld32, vld64, q.size() > 0); else passed++;
      total++; if (rdy32 !== (q.size() < 2) || rdy64 !== (q.size() < 2))
        $display("FAIL rnd_ready c%0d got %b/%b want %b", cyc, rdy32, rdy64, q.size() < 2); else passed++;
      if (q.size() > 0) begin
        total++; if (imm32 !== q[0].imm32 || tgt32 !== q[0].tgt32 || err32 !== q[0].err)
          $display("FAIL rnd_head32 c%0d got %h %h %b want %h %h %b", cyc, imm32, tgt32, err32,
                   q[0].imm32, q[0].tgt32, q[0].err); else passed++;
        total++; if (imm64 !== q[0].imm64 || tgt64 !== q[0].tgt64 || err64 !== q[0].err)
          $display("FAIL rnd_head64 c%0d got %h %h %b want %h %h %b", cyc, imm64, tgt64, err64,
                   q[0].imm64, q[0].tgt64, q[0].err); else passed++;
      end
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 31) == 0);
      in_inst    = $urandom;
      in_pc      = $urandom;
      in_imm_sel = 3'($urandom_range(0, 7));
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          e.imm32 = 32'(ref_imm(in_inst, in_imm_sel, 1'b0));
          e.imm64 = ref_imm(in_inst, in_imm_sel, 1'b1);
          e.tgt32 = in_pc + e.imm32;
          e.tgt64 = in_pc + e.imm64[31:0];
          e.err   = (in_imm_sel == 3'd7);
          q.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset_init();
    test_formats();
    test_branch_target();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
